// File: rtl/cdda_stream_ctrl.sv
// CD-DA sample stream buffer: CPU-filled stereo frame RAM drained by a serialiser.
// Optional loop mode (LOOPSTART, CTRL bit2) built only with CDDA_STREAM_LOOP_EN.
module cdda_stream_ctrl #(
   parameter int ADDR_BITS   = 8,
   parameter int SAMPLE_BITS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_BITS+3:0]   sram_a,
   input  logic [7:0]             sram_d_in,
   output logic [7:0]             sram_d_out,
   input  logic                   sram_cs,
   input  logic                   sram_oe,
   input  logic                   sram_we,
   output logic                   sram_wait,
   input  logic                   sample_req,
   output logic [SAMPLE_BITS-1:0] left_out,
   output logic [SAMPLE_BITS-1:0] right_out,
   output logic                   play_en,
   output logic                   irq
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int LANES = SAMPLE_BITS / 8;

   typedef logic [ADDR_BITS-1:0]   ptr_t;
   typedef logic [SAMPLE_BITS-1:0] smp_t;

   localparam logic [2:0] R_CTRL  = 3'd0;
   localparam logic [2:0] R_RDPOS = 3'd1;
   localparam logic [2:0] R_LAST  = 3'd2;
   localparam logic [2:0] R_SCR   = 3'd3;
   localparam logic [2:0] R_LOOP  = 3'd4;
   localparam logic [2:0] R_LOW   = 3'd5;
   localparam logic [2:0] R_FILL  = 3'd6;
   localparam logic [2:0] R_UFC   = 3'd7;

   smp_t mem_l [DEPTH];
   smp_t mem_r [DEPTH];
   smp_t left_q;
   smp_t right_q;

   logic       enabled;
   logic       underflow;
   logic       loop_q;
   logic       irq_en;
   logic       irq_pending;
   ptr_t       rdpos;
   ptr_t       last;
   ptr_t       loopstart;
   ptr_t       lowwater;
   logic [7:0] scratch;
   logic [7:0] ufcount;

   logic       wr;
   logic       buf_sel;
   logic       buf_wr;
   logic       reg_wr;
   logic [2:0] reg_idx;
   ptr_t       buf_idx;
   logic       buf_ch;
   logic [1:0] lane;
   logic       wr_ctrl;
   logic       wr_rdpos;
   logic       wr_last;
   logic       wr_scr;
   logic       wr_loop;
   logic       wr_low;
   logic       wr_ack;
   logic       wr_ufc;

   logic       step;
   logic       at_end;
   logic       adv;
   logic       loop_jump;
   logic       uf_evt;
   logic       lw_hit;
   ptr_t       rdpos_inc;
   ptr_t       fill;
   ptr_t       fill_adv;
   logic [7:0] reg_rd;

   assign wr      = sram_cs & sram_we;
   assign buf_sel = sram_a[ADDR_BITS+3];
   assign buf_wr  = wr & buf_sel;
   assign reg_wr  = wr & ~buf_sel;
   assign reg_idx = sram_a[2:0];
   assign buf_idx = sram_a[ADDR_BITS+1:2];
   assign buf_ch  = sram_a[ADDR_BITS+2];
   assign lane    = sram_a[1:0];

   assign wr_ctrl  = reg_wr && (reg_idx == R_CTRL);
   assign wr_rdpos = reg_wr && (reg_idx == R_RDPOS);
   assign wr_last  = reg_wr && (reg_idx == R_LAST);
   assign wr_scr   = reg_wr && (reg_idx == R_SCR);
   assign wr_loop  = reg_wr && (reg_idx == R_LOOP);
   assign wr_low   = reg_wr && (reg_idx == R_LOW);
   assign wr_ack   = reg_wr && (reg_idx == R_FILL);
   assign wr_ufc   = reg_wr && (reg_idx == R_UFC);

   // End of data either loops back or underflows; never both.
   assign step      = sample_req & enabled;
   assign at_end    = (rdpos == last);
   assign adv       = step & ~at_end;
   assign loop_jump = step & at_end & loop_q;
   assign uf_evt    = step & at_end & ~loop_q;
   assign rdpos_inc = rdpos + ptr_t'(1);
   assign fill      = last - rdpos;
   assign fill_adv  = last - rdpos_inc;
   assign lw_hit    = adv && (fill_adv == lowwater);

   always_ff @(posedge clk) begin
      if (rst) begin
         enabled     <= 1'b0;
         underflow   <= 1'b0;
         irq_en      <= 1'b0;
         irq_pending <= 1'b0;
         rdpos       <= '0;
         last        <= '0;
         lowwater    <= '0;
         scratch     <= 8'h55;
         ufcount     <= 8'h00;
         play_en     <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            enabled <= sram_d_in[0];
            irq_en  <= sram_d_in[3];
         end
         if (wr_ctrl && sram_d_in[1])
            underflow <= 1'b0;
         else if (uf_evt)
            underflow <= 1'b1;
         if (wr_rdpos)
            rdpos <= sram_d_in[ADDR_BITS-1:0];
         else if (adv)
            rdpos <= rdpos_inc;
         else if (loop_jump)
            rdpos <= loopstart;
         if (wr_last)
            last <= sram_d_in[ADDR_BITS-1:0];
         if (wr_low)
            lowwater <= sram_d_in[ADDR_BITS-1:0];
         if (wr_scr)
            scratch <= sram_d_in;
         if (wr_ufc)
            ufcount <= 8'h00;
         else if (uf_evt && ufcount != 8'hFF)
            ufcount <= ufcount + 8'd1;
         // A new event wins over an acknowledge in the same cycle.
         if (uf_evt || lw_hit)
            irq_pending <= 1'b1;
         else if (wr_ack)
            irq_pending <= 1'b0;
         if (enabled)
            play_en <= 1'b1;
         else if (sample_req)
            play_en <= 1'b0;
      end
   end

`ifdef CDDA_STREAM_LOOP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         loop_q    <= 1'b0;
         loopstart <= '0;
      end else begin
         if (wr_ctrl)
            loop_q <= sram_d_in[2];
         if (wr_loop)
            loopstart <= sram_d_in[ADDR_BITS-1:0];
      end
   end
`else
   logic unused_loop;
   assign unused_loop = wr_loop;
   assign loop_q      = 1'b0;
   assign loopstart   = '0;
`endif

   always_ff @(posedge clk) begin
      if (buf_wr) begin
         for (int k = 0; k < LANES; k++) begin
            if (lane == 2'(k)) begin
               if (buf_ch)
                  mem_r[buf_idx][k*8 +: 8] <= sram_d_in;
               else
                  mem_l[buf_idx][k*8 +: 8] <= sram_d_in;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         left_q  <= '0;
         right_q <= '0;
      end else begin
         left_q  <= mem_l[rdpos];
         right_q <= mem_r[rdpos];
      end
   end

   assign left_out  = underflow ? '0 : left_q;
   assign right_out = underflow ? '0 : right_q;

   always_comb begin
      reg_rd = 8'h00;
      unique case (reg_idx)
         R_CTRL:  reg_rd = {3'b000, irq_pending, irq_en,
                            loop_q, underflow, enabled};
         R_RDPOS: reg_rd = 8'(rdpos);
         R_LAST:  reg_rd = 8'(last);
         R_SCR:   reg_rd = scratch;
         R_LOOP:  reg_rd = 8'(loopstart);
         R_LOW:   reg_rd = 8'(lowwater);
         R_FILL:  reg_rd = 8'(fill);
         R_UFC:   reg_rd = ufcount;
      endcase
   end

   assign sram_d_out = (sram_cs && sram_oe && !buf_sel) ? reg_rd : 8'h00;
   assign sram_wait  = 1'b0;
   assign irq        = irq_pending & irq_en;

endmodule

// File: tb/tb_cdda_stream_ctrl.sv
// Directed bench for cdda_stream_ctrl: playback, underflow, wrap, irq, loop,
// same-cycle priorities, UFCOUNT saturation and mid-playback reset.
module tb_cdda_stream_ctrl;

   localparam int AB = 8;
   localparam int SB = 16;
   localparam int AW = AB + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] sram_a;
   logic [7:0]    sram_d_in;
   logic [7:0]    sram_d_out;
   logic          sram_cs;
   logic          sram_oe;
   logic          sram_we;
   logic          sram_wait;
   logic          sample_req;
   logic [SB-1:0] left_out;
   logic [SB-1:0] right_out;
   logic          play_en;
   logic          irq;

   int n_pass = 0;
   int n_chk  = 0;

`ifdef CDDA_STREAM_LOOP_EN
   localparam logic [7:0] UF_BASE = 8'd1;
`else
   localparam logic [7:0] UF_BASE = 8'd2;
`endif

   cdda_stream_ctrl #(.ADDR_BITS(AB), .SAMPLE_BITS(SB)) dut (
      .clk(clk), .rst(rst), .sram_a(sram_a), .sram_d_in(sram_d_in),
      .sram_d_out(sram_d_out), .sram_cs(sram_cs), .sram_oe(sram_oe),
      .sram_we(sram_we), .sram_wait(sram_wait), .sample_req(sample_req),
      .left_out(left_out), .right_out(right_out), .play_en(play_en),
      .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] ra(input int r);
      return AW'(r);
   endfunction

   function automatic logic [AW-1:0] ba(input logic ch, input int idx,
                                        input int ln);
      logic [AB-1:0] i;
      logic [1:0]    l;
      i = AB'(idx);
      l = 2'(ln);
      return {1'b1, ch, i, l};
   endfunction

   task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      sram_a = a; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
      @(negedge clk);
      sram_cs = 1'b0; sram_we = 1'b0;
   endtask

   task automatic wr_req(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      sram_a = a; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
      sample_req = 1'b1;
      @(negedge clk);
      sram_cs = 1'b0; sram_we = 1'b0; sample_req = 1'b0;
   endtask

   task automatic req();
      @(negedge clk);
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [7:0] d);
      @(negedge clk);
      sram_a = a; sram_cs = 1'b1; sram_oe = 1'b1;
      #1 d = sram_d_out;
      sram_cs = 1'b0; sram_oe = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      sram_a = '0; sram_d_in = 8'h00; sram_cs = 1'b0;
      sram_oe = 1'b0; sram_we = 1'b0; sample_req = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (play_en !== 1'b0 || irq !== 1'b0 || sram_wait !== 1'b0)
         $display("FAIL rst_outs: got pe=%b irq=%b wait=%b want 0 0 0",
                  play_en, irq, sram_wait);
      else n_pass++;
      n_chk++;
      if (left_out !== 16'h0 || right_out !== 16'h0)
         $display("FAIL rst_samples: got %h/%h want 0/0",
                  left_out, right_out);
      else n_pass++;
      rd(ra(0), v); n_chk++;
      if (v !== 8'h00) $display("FAIL rst_ctrl: got %h want 00", v);
      else n_pass++;
      rd(ra(3), v); n_chk++;
      if (v !== 8'h55) $display("FAIL rst_scratch: got %h want 55", v);
      else n_pass++;
      rd(ra(1), v); n_chk++;
      if (v !== 8'h00) $display("FAIL rst_rdpos: got %h want 00", v);
      else n_pass++;
      rd(ra(7), v); n_chk++;
      if (v !== 8'h00) $display("FAIL rst_ufcount: got %h want 00", v);
      else n_pass++;
      rd(ra(6), v); n_chk++;
      if (v !== 8'h00) $display("FAIL rst_fill: got %h want 00", v);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_playback();
      logic [7:0] v;
      for (int i = 0; i < 10; i++) begin
         wr(ba(1'b0, i, 0), 8'(i));
         wr(ba(1'b0, i, 1), 8'h10);
         wr(ba(1'b1, i, 0), 8'(i));
         wr(ba(1'b1, i, 1), 8'h20);
      end
      wr(ra(2), 8'd9);
      wr(ra(0), 8'h01);
      n_chk++;
      if (play_en !== 1'b0)
         $display("FAIL play_en_early: got %b want 0", play_en);
      else n_pass++;
      @(negedge clk); n_chk++;
      if (play_en !== 1'b1 || left_out !== 16'h1000)
         $display("FAIL play_start: got pe=%b l=%h want 1 1000",
                  play_en, left_out);
      else n_pass++;
      repeat (9) req();
      n_chk++;
      if (left_out !== 16'h1008)
         $display("FAIL out_latency: got %h want 1008", left_out);
      else n_pass++;
      @(negedge clk); n_chk++;
      if (left_out !== 16'h1009 || right_out !== 16'h2009)
         $display("FAIL out_frame9: got %h/%h want 1009/2009",
                  left_out, right_out);
      else n_pass++;
      rd(ra(1), v); n_chk++;
      if (v !== 8'd9) $display("FAIL rdpos9: got %h want 09", v);
      else n_pass++;
      rd(ra(0), v); n_chk++;
      if (v !== 8'h11) $display("FAIL ctrl_fill0: got %h want 11", v);
      else n_pass++;
      wr(ra(6), 8'h00);
      wr(ra(0), 8'h09);
      n_chk++;
      if (irq !== 1'b0) $display("FAIL irq_pre_uf: got %b want 0", irq);
      else n_pass++;
      req();
      n_chk++;
      if (irq !== 1'b1 || left_out !== 16'h0 || right_out !== 16'h0)
         $display("FAIL uf_event: got irq=%b %h/%h want 1 0/0",
                  irq, left_out, right_out);
      else n_pass++;
      rd(ra(7), v); n_chk++;
      if (v !== 8'd1) $display("FAIL ufcount1: got %h want 01", v);
      else n_pass++;
      rd(ra(0), v); n_chk++;
      if (v !== 8'h1B) $display("FAIL ctrl_uf: got %h want 1b", v);
      else n_pass++;
      wr(ra(0), 8'h0B);
      n_chk++;
      if (left_out !== 16'h1009 || right_out !== 16'h2009)
         $display("FAIL uf_clear_out: got %h/%h want 1009/2009",
                  left_out, right_out);
      else n_pass++;
      rd(ra(0), v); n_chk++;
      if (v !== 8'h19) $display("FAIL ctrl_ufclr: got %h want 19", v);
      else n_pass++;
      wr(ra(6), 8'h00);
      n_chk++;
      if (irq !== 1'b0) $display("FAIL irq_ack: got %b want 0", irq);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [7:0] v;
      wr(ra(1), 8'hFF);
      wr(ra(2), 8'd3);
      req();
      rd(ra(1), v); n_chk++;
      if (v !== 8'h00) $display("FAIL wrap_rdpos: got %h want 00", v);
      else n_pass++;
      rd(ra(6), v); n_chk++;
      if (v !== 8'h03) $display("FAIL wrap_fill: got %h want 03", v);
      else n_pass++;
   endtask

   task automatic test_lowwater();
      logic [7:0] v;
      wr(ra(5), 8'd2);
      wr(ra(2), 8'd5);
      wr(ra(1), 8'd2);
      wr(ra(6), 8'h00);
      n_chk++;
      if (irq !== 1'b0) $display("FAIL lw_pre: got %b want 0", irq);
      else n_pass++;
      req();
      n_chk++;
      if (irq !== 1'b1) $display("FAIL lw_irq: got %b want 1", irq);
      else n_pass++;
      rd(ra(6), v); n_chk++;
      if (v !== 8'd2) $display("FAIL lw_fill: got %h want 02", v);
      else n_pass++;
      wr(ra(6), 8'h00);
      n_chk++;
      if (irq !== 1'b0) $display("FAIL lw_ack: got %b want 0", irq);
      else n_pass++;
   endtask

   task automatic test_loop();
      logic [7:0] v;
      wr(ra(2), 8'd7);
      wr(ra(1), 8'd7);
      wr(ra(4), 8'd2);
      wr(ra(0), 8'h05);
`ifdef CDDA_STREAM_LOOP_EN
      rd(ra(0), v); n_chk++;
      if (v !== 8'h05) $display("FAIL loop_ctrl: got %h want 05", v);
      else n_pass++;
      rd(ra(4), v); n_chk++;
      if (v !== 8'h02) $display("FAIL loop_start: got %h want 02", v);
      else n_pass++;
      req();
      rd(ra(1), v); n_chk++;
      if (v !== 8'h02) $display("FAIL loop_rdpos: got %h want 02", v);
      else n_pass++;
      rd(ra(0), v); n_chk++;
      if (v !== 8'h05) $display("FAIL loop_no_uf: got %h want 05", v);
      else n_pass++;
`else
      rd(ra(0), v); n_chk++;
      if (v !== 8'h01) $display("FAIL loop_ctrl: got %h want 01", v);
      else n_pass++;
      rd(ra(4), v); n_chk++;
      if (v !== 8'h00) $display("FAIL loop_start: got %h want 00", v);
      else n_pass++;
      req();
      rd(ra(1), v); n_chk++;
      if (v !== 8'h07) $display("FAIL loop_rdpos: got %h want 07", v);
      else n_pass++;
      rd(ra(0), v); n_chk++;
      if (v !== 8'h13) $display("FAIL loop_uf: got %h want 13", v);
      else n_pass++;
`endif
      rd(ra(7), v); n_chk++;
      if (v !== UF_BASE)
         $display("FAIL loop_ufcount: got %h want %h", v, UF_BASE);
      else n_pass++;
      wr(ra(0), 8'h03);
      wr(ra(6), 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      wr(ra(2), 8'h40);
      wr(ra(1), 8'd5);
      wr_req(ra(1), 8'h20);
      rd(ra(1), v); n_chk++;
      if (v !== 8'h20) $display("FAIL b2b_rdpos_wr: got %h want 20", v);
      else n_pass++;
      req();
      rd(ra(6), v); n_chk++;
      if (v !== 8'h1F) $display("FAIL b2b_fill: got %h want 1f", v);
      else n_pass++;
      wr(ra(1), 8'h40);
      wr_req(ra(0), 8'h03);
      rd(ra(0), v); n_chk++;
      if (v !== 8'h11) $display("FAIL b2b_ufclr: got %h want 11", v);
      else n_pass++;
      rd(ra(7), v); n_chk++;
      if (v !== UF_BASE + 8'd1)
         $display("FAIL b2b_ufc_a: got %h want %h", v, UF_BASE + 8'd1);
      else n_pass++;
      wr_req(ra(6), 8'h00);
      rd(ra(0), v); n_chk++;
      if (v !== 8'h13) $display("FAIL b2b_ack_set: got %h want 13", v);
      else n_pass++;
      wr(ra(0), 8'h00);
      repeat (3) @(negedge clk);
      n_chk++;
      if (play_en !== 1'b1)
         $display("FAIL b2b_pe_hold: got %b want 1", play_en);
      else n_pass++;
      req();
      n_chk++;
      if (play_en !== 1'b0)
         $display("FAIL b2b_pe_drop: got %b want 0", play_en);
      else n_pass++;
      rd(ra(7), v); n_chk++;
      if (v !== UF_BASE + 8'd2)
         $display("FAIL b2b_ufc_b: got %h want %h", v, UF_BASE + 8'd2);
      else n_pass++;
      wr(ra(0), 8'h02);
      wr(ra(6), 8'h00);
      rd(ra(0), v); n_chk++;
      if (v !== 8'h00) $display("FAIL b2b_idle: got %h want 00", v);
      else n_pass++;
   endtask

   task automatic test_ufcount();
      logic [7:0] v;
      wr(ra(7), 8'h5A);
      rd(ra(7), v); n_chk++;
      if (v !== 8'h00) $display("FAIL ufc_clear: got %h want 00", v);
      else n_pass++;
      wr(ra(0), 8'h01);
      repeat (260) req();
      rd(ra(7), v); n_chk++;
      if (v !== 8'hFF) $display("FAIL ufc_sat: got %h want ff", v);
      else n_pass++;
      wr(ra(0), 8'h02);
      wr(ra(6), 8'h00);
   endtask

   task automatic test_regs();
      logic [7:0] v;
      wr(ra(3), 8'hA5);
      rd(ra(3), v); n_chk++;
      if (v !== 8'hA5) $display("FAIL scratch_rw: got %h want a5", v);
      else n_pass++;
      rd(ba(1'b0, 5, 1), v); n_chk++;
      if (v !== 8'h00) $display("FAIL buf_read: got %h want 00", v);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      wr(ra(1), 8'd0);
      wr(ra(2), 8'd9);
      wr(ra(0), 8'h01);
      @(negedge clk);
      req();
      @(negedge clk); n_chk++;
      if (play_en !== 1'b1 || left_out !== 16'h1001)
         $display("FAIL mid_play: got pe=%b l=%h want 1 1001",
                  play_en, left_out);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk); n_chk++;
      if (play_en !== 1'b0 || left_out !== 16'h0 || right_out !== 16'h0)
         $display("FAIL mid_rst: got pe=%b %h/%h want 0 0/0",
                  play_en, left_out, right_out);
      else n_pass++;
      rd(ra(1), v); n_chk++;
      if (v !== 8'h00) $display("FAIL mid_rst_rdpos: got %h want 00", v);
      else n_pass++;
      rd(ra(3), v); n_chk++;
      if (v !== 8'h55) $display("FAIL mid_rst_scr: got %h want 55", v);
      else n_pass++;
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_playback();
      test_wrap();
      test_lowwater();
      test_loop();
      test_back_to_back();
      test_ufcount();
      test_regs();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
